fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end that feeds the decode stage.
- Generates the sequential fetch PC and issues requests to a pipelined instruction memory using a request/grant handshake with in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode under a valid/ready handshake.
- Handles branch/jump redirects from the execute stage by flushing the FIFO and discarding in-flight responses. When no instruction is available, decode receives a bubble.

Parameters:
DEPTH, 4, FIFO entries; also caps FIFO occupancy plus outstanding requests (power of 2, ≥2)
MAX_OUTSTANDING, 2, maximum issued-but-unreturned memory requests
RESET_PC, 32'h0000_0000, first fetch address after reset
BUBBLE, 32'h0000_0013, instruction word driven when id_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (word aligned)
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid (in order, ≥1 cycle after grant)
imem_rdata  in  32  response instruction word
redirect_valid  in  1  branch/jump taken in execute this cycle
redirect_target  in  32  new fetch address
id_valid  out  1  id_inst/id_pc hold a real instruction
id_ready  in  1  decode accepts (0 = stall)
id_pc  out  32  PC of presented instruction
id_inst  out  32  presented instruction, BUBBLE when id_valid=0
fetch_err  out  1  sticky protocol-error flag

Behaviour:
- State: req_pc, resp_pc, FIFO of {pc, inst} with count, outstanding counter, drop counter, err flag.
- Reset (asynchronous, any time including mid-transfer):
  - req_pc = resp_pc = RESET_PC; count = outstanding = drop = 0; fetch_err = 0.
  - Outputs while reset is high: imem_req=0, id_valid=0, id_inst=BUBBLE, id_pc=0.
- Issue:
  - imem_req = !redirect_valid && outstanding < MAX_OUTSTANDING && (count + outstanding) < DEPTH.
  - imem_addr = req_pc.
  - On imem_req && imem_gnt: req_pc += 4 and outstanding += 1.
  - While not granted, imem_addr holds stable.
- Response (imem_rvalid=1):
  - outstanding -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise push {resp_pc, imem_rdata} and resp_pc += 4.
  - The issue guard guarantees space, so there is no back-pressure on rvalid.
- Pop:
  - id_valid = (count != 0) && !redirect_valid.
  - id_pc/id_inst come from the FIFO head.
  - An entry is removed when id_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
- Latency:
  - No bypass: a response pushed at the end of cycle N is visible at cycle N+1.
  - Minimum grant-to-id_valid latency is 2 cycles.
  - Throughput is 1 instruction/cycle with 1-cycle memory latency and MAX_OUTSTANDING=2.
- Redirect (redirect_valid=1, highest priority):
  - FIFO is flushed (count=0) and id_valid is forced 0 in that cycle; any pop is ignored.
  - No issue that cycle.
  - drop = outstanding minus 1 if rvalid arrives the same cycle (that response is discarded directly).
  - req_pc = resp_pc = {redirect_target[31:2], 2'b00}.
  - A redirect while drop > 0 accumulates correctly; outstanding remains the total number of responses still due.
- Wrap-around: req_pc/resp_pc wrap modulo 2^32; the FIFO pointers wrap modulo DEPTH.
- Error: imem_rvalid while outstanding==0 sets fetch_err (sticky until reset); the response is ignored and no counter underflows.

Test Plan:
- Reset, imem_gnt=1, 1-cycle memory latency, id_ready=1 -> id_valid rises 2 cycles after the first grant; id_pc = 0,4,8,12… on consecutive cycles; id_inst matches memory.
- id_ready=0 for 8 cycles -> count reaches 4, imem_req=0 once count+outstanding=4, id_inst/id_pc held at PC 0 entry. Release -> PCs 0,4,8,12,16 in order with none lost or duplicated.
- Redirect to 0x100 with 2 requests outstanding -> those 2 responses discarded, FIFO empty; next id_valid shows id_pc=0x100, then 0x104.
- Redirect target 0x203 -> imem_addr=0x200 on the next request; id_pc=0x200.
- imem_gnt=0 for 3 cycles -> imem_req stays 1, imem_addr stable at the same PC, outstanding unchanged.
- imem_rvalid pulse with nothing outstanding -> fetch_err=1 sticky, FIFO unchanged. Assert reset mid-stream -> all outputs return to reset values immediately, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC generation, in-order memory requests, decode FIFO
module fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] BUBBLE          = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        fetch_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   req_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop;
    logic          err;

    logic rsp_ok;
    logic issue_ok;
    logic grant;
    logic push;
    logic pop;

    // Issue guard reserves a FIFO slot for every in-flight request, so responses never stall.
    always_comb begin
        rsp_ok    = imem_rvalid && (outstanding != '0);
        issue_ok  = (32'(outstanding) < MAX_OUTSTANDING)
                 && ((32'(count) + 32'(outstanding)) < DEPTH);
        imem_req  = !reset && !redirect_valid && issue_ok;
        imem_addr = req_pc;
        grant     = imem_req && imem_gnt;
        push      = rsp_ok && (drop == '0) && !redirect_valid;
        id_valid  = !reset && (count != '0) && !redirect_valid;
        pop       = id_valid && id_ready;
        id_pc     = id_valid ? fifo_pc[rd_ptr] : 32'h0;
        id_inst   = id_valid ? fifo_inst[rd_ptr] : BUBBLE;
        fetch_err = err;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc      <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            err         <= 1'b0;
        end else begin
            if (imem_rvalid && (outstanding == '0)) begin
                err <= 1'b1;
            end
            if (redirect_valid) begin
                // Every response still due after this cycle belongs to the old path.
                req_pc      <= {redirect_target[31:2], 2'b00};
                resp_pc     <= {redirect_target[31:2], 2'b00};
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                outstanding <= outstanding - OW'(rsp_ok);
                drop        <= outstanding - OW'(rsp_ok);
            end else begin
                if (grant) begin
                    req_pc <= req_pc + 32'd4;
                end
                outstanding <= outstanding + OW'(grant) - OW'(rsp_ok);
                if (rsp_ok && (drop != '0)) begin
                    drop <= drop - OW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule
